// File: rtl/ps2_receiver.sv
// PS/2 device-to-host receiver: synchronizes ps2_clk/ps2_data, assembles 11-bit
// frames on ps2_clk falling edges, and queues valid scan-code bytes in a FIFO.
module ps2_receiver #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  input  logic       ovf_clr,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_CYCLES);

  // Input synchronizers plus a history flop on ps2_clk for edge detection.
  logic clk_s1, clk_s2, clk_hist;
  logic dat_s1, dat_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_hist <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      clk_hist <= clk_s2;
      dat_s1   <= ps2_data;
      dat_s2   <= dat_s1;
    end
  end

  logic fall;
  assign fall = clk_hist & ~clk_s2;

  // The shift register keeps the ten bits already sampled; the live sample
  // completes the 11-bit frame {stop, parity, d7..d0, start}.
  logic [9:0]    shift_reg;
  logic [3:0]    bit_cnt;
  logic [TW-1:0] tcnt;
  logic [10:0]   frame;
  logic          frame_done;
  logic          frame_ok;
  logic          timeout_hit;

  assign frame       = {dat_s2, shift_reg};
  assign frame_done  = fall && (bit_cnt == 4'd10);
  assign frame_ok    = frame_done && !frame[0] && frame[10] && (^frame[9:1]);
  assign timeout_hit = !fall && (bit_cnt != 4'd0) && (tcnt == TO_LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      tcnt      <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= (frame_done && !frame_ok) || timeout_hit;
      if (fall) begin
        shift_reg <= frame[10:1];
        tcnt      <= '0;
        bit_cnt   <= (bit_cnt == 4'd10) ? 4'd0 : bit_cnt + 4'd1;
      end else if (timeout_hit) begin
        bit_cnt <= '0;
        tcnt    <= '0;
      end else if (bit_cnt != 4'd0) begin
        tcnt <= tcnt + 1'b1;
      end
    end
  end

  // Receive FIFO. When full, a simultaneous pop frees the head slot, which is
  // exactly the slot the write pointer addresses, so the push can proceed.
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic pop, full, push_ok, drop;

  assign pop     = !nextdata_n && (count != '0);
  assign full    = (count == FULL_CNT);
  assign push_ok = frame_ok && (!full || pop);
  assign drop    = frame_ok && full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wptr] <= frame[8:1];
        wptr      <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  assign data  = mem[rptr];
  assign ready = (count != '0);

endmodule

// File: tb/tb_ps2_receiver.sv
// Bench for ps2_receiver: frames driven bit by bit, expected bytes and
// frame_err pulses queued by the driver and consumed by a monitor.
module tb_ps2_receiver;

  localparam int DEPTH = 8;
  localparam int TO    = 200;
  localparam int HALF  = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk, ps2_data, nextdata_n, ovf_clr;
  logic [7:0] data;
  logic       ready, overflow, frame_err;

  ps2_receiver #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .nextdata_n(nextdata_n), .ovf_clr(ovf_clr), .data(data),
    .ready(ready), .overflow(overflow), .frame_err(frame_err)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard state and reference model
  logic [7:0] exp_q[$];
  int  err_pend  = 0;
  bit  model_ovf = 0;
  int  n_cmp = 0;
  int  n_bad = 0;
  bit  prev_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Driver tasks
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    cyc(HALF);
    ps2_clk = 1'b0;
    cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad_start,
                                             input bit bad_par, input bit bad_stop);
    logic par;
    par = ~(^b) ^ bad_par;
    return {~bad_stop, par, b, bad_start};
  endfunction

  task automatic send_frame(input logic [7:0] b, input bit bad_start,
                            input bit bad_par, input bit bad_stop);
    logic [10:0] f;
    bit valid;
    f = make_frame(b, bad_start, bad_par, bad_stop);
    valid = !bad_start && !bad_par && !bad_stop;
    if (!valid) err_pend++;
    for (int i = 0; i < 11; i++) send_bit(f[i]);
    cyc(6);
    if (valid) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else model_ovf = 1;
    end
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    logic [10:0] f;
    f = make_frame(b, 0, 0, 0);
    for (int i = 0; i < nbits; i++) send_bit(f[i]);
  endtask

  task automatic pop_one();
    nextdata_n = 1'b0;
    cyc(1);
    nextdata_n = 1'b1;
    cyc(1);
  endtask

  task automatic clr_ovf();
    ovf_clr = 1'b1;
    cyc(1);
    ovf_clr = 1'b0;
    model_ovf = 0;
    cyc(1);
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_ready"}, ready, exp_q.size() != 0);
    if (exp_q.size() != 0) chk({tag, "_data"}, data, exp_q[0]);
    chk({tag, "_overflow"}, overflow, model_ovf);
  endtask

  // Monitor: consumes expected pops and frame_err pulses
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) begin
        chk("frame_err_expected", err_pend > 0, 1);
        if (err_pend > 0) err_pend--;
        chk("frame_err_width", prev_err, 0);
      end
      prev_err = frame_err;
      if (!nextdata_n) begin
        if (exp_q.size() != 0) begin
          chk("pop_ready", ready, 1);
          chk("pop_data", data, exp_q.pop_front());
        end else begin
          chk("pop_empty_ready", ready, 0);
        end
      end
    end else begin
      prev_err = 0;
    end
  end

  // Stimulus
  initial begin
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; nextdata_n = 1'b1; ovf_clr = 1'b0;
    cyc(5);
    chk("rst_data", data, 8'h00);
    chk("rst_ready", ready, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_frame_err", frame_err, 0);
    rst = 1'b0;
    cyc(5);
    check_state("post_rst");

    // Single good frame, then pop
    send_frame(8'h1C, 0, 0, 0);
    check_state("f1c");
    pop_one();
    check_state("f1c_popped");

    // Parity error
    send_frame(8'h1C, 0, 1, 0);
    cyc(2);
    check_state("bad_par");

    // Two frames, ordered pops
    send_frame(8'hF0, 0, 0, 0);
    send_frame(8'h1C, 0, 0, 0);
    check_state("two");
    pop_one();
    check_state("two_pop1");
    pop_one();
    check_state("two_pop2");

    // Overflow with nine frames
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 0, 0);
    check_state("ovf_full");
    for (int i = 0; i < DEPTH; i++) begin
      pop_one();
      check_state("ovf_drain");
    end
    pop_one();
    check_state("ovf_empty_pop");
    clr_ovf();
    check_state("ovf_cleared");

    // Timeout of a partial frame
    err_pend++;
    send_partial(8'h55, 4);
    cyc(TO + 10);
    check_state("timeout");
    send_frame(8'h32, 0, 0, 0);
    check_state("after_timeout");
    pop_one();

    // Reset mid-frame
    send_partial(8'h1C, 5);
    rst = 1'b1;
    cyc(3);
    chk("midrst_ready", ready, 0);
    chk("midrst_data", data, 8'h00);
    rst = 1'b0;
    exp_q.delete();
    model_ovf = 0;
    cyc(3);
    send_frame(8'h32, 0, 0, 0);
    check_state("after_midrst");
    pop_one();

    // Randomized frames, errors, pops and overflow clears
    for (int it = 0; it < 24; it++) begin
      int kind;
      int npop;
      logic [7:0] b;
      b    = 8'($urandom_range(0, 255));
      kind = $urandom_range(0, 7);
      send_frame(b, kind == 0, kind == 1, kind == 2);
      check_state("rnd_rx");
      if ($urandom_range(0, 3) == 0) clr_ovf();
      npop = $urandom_range(0, 2);
      for (int p = 0; p < npop; p++) begin
        pop_one();
        check_state("rnd_pop");
      end
    end

    cyc(20);
    chk("err_pending_zero", err_pend, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
